// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between instruction fetch and
// the load/store path. Each access runs IDLE -> ISSUE -> WAIT -> DONE. The
// completion ack is a one-cycle pulse, and read data is held in a per-port
// register until the next ack. While any request is unacknowledged, the
// pipeline sees a combinational stall.
//
// Optional build macro ARB_FAIRNESS_EN: alternate priority between data and
// fetch using a one-bit last-owner register. Without the macro, data always
// wins over fetch.
module mem_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          cnt_r;
    logic                owner_d_r;
    logic                store_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                mem_en_r;
    logic                mem_we_r;
    logic                if_ack_r;
    logic                d_ack_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   d_rdata_r;
    logic                blk_d_r;
    logic                blk_i_r;

    logic                d_req_s;
    logic                d_elig_s;
    logic                i_elig_s;
    logic                grant_d_s;
    logic                grant_i_s;
    logic                grant_s;
    logic                last_cnt_s;

`ifdef ARB_FAIRNESS_EN
    logic                last_d_r;
`endif

    // A port that was just acked still shows its old request for one IDLE
    // cycle, so it is masked out of that arbitration.
    assign d_req_s    = d_read | d_write;
    assign d_elig_s   = d_req_s & ~blk_d_r;
    assign i_elig_s   = if_req & ~blk_i_r;
    assign grant_s    = grant_d_s | grant_i_s;
    assign last_cnt_s = (state_r == WAIT) && (cnt_r == 4'd1);

    assign stall     = (if_req & ~if_ack_r) | (d_req_s & ~d_ack_r);
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign if_ack    = if_ack_r;
    assign d_ack     = d_ack_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;

    // Arbitration between eligible requests, evaluated only in IDLE.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == IDLE) begin
`ifdef ARB_FAIRNESS_EN
            if (d_elig_s && i_elig_s) begin
                grant_d_s = ~last_d_r;
                grant_i_s = last_d_r;
            end else begin
                grant_d_s = d_elig_s;
                grant_i_s = i_elig_s;
            end
`else
            grant_d_s = d_elig_s;
            grant_i_s = i_elig_s & ~d_elig_s;
`endif
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture the winner's address, write data and direction at grant time.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            owner_d_r <= 1'b0;
            store_r   <= 1'b0;
        end else if (grant_s) begin
            addr_r    <= grant_d_s ? d_addr : if_addr;
            wdata_r   <= grant_d_s ? d_wdata : {DATA_W{1'b0}};
            owner_d_r <= grant_d_s;
            store_r   <= grant_d_s & d_write;
        end
    end

    // Memory strobe and write enable: high only during the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
        end else begin
            mem_en_r <= grant_s;
            mem_we_r <= grant_d_s & d_write;
        end
    end

    // Latency counter: loaded in ISSUE and counted down while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if (state_r == ISSUE) begin
            cnt_r <= LAT_INIT;
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Capture returned data into the owner's register and raise the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_ack_r   <= 1'b0;
            d_ack_r    <= 1'b0;
            if_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            if_ack_r <= last_cnt_s & ~owner_d_r;
            d_ack_r  <= last_cnt_s & owner_d_r;
            if (last_cnt_s && !owner_d_r) begin
                if_rdata_r <= mem_rdata;
            end
            if (last_cnt_s && owner_d_r && !store_r) begin
                d_rdata_r <= mem_rdata;
            end
        end
    end

    // Mask the just-acked port for the IDLE cycle that follows its ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_d_r <= 1'b0;
            blk_i_r <= 1'b0;
        end else begin
            blk_d_r <= (state_r == DONE) && owner_d_r;
            blk_i_r <= (state_r == DONE) && !owner_d_r;
        end
    end

`ifdef ARB_FAIRNESS_EN
    // Remember the last grant owner; reset to fetch so data wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_r <= 1'b0;
        end else if (grant_s) begin
            last_d_r <= grant_d_s;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a driver issues transactions and
// pushes expected accesses/acks into queues. A negedge monitor pops and
// compares them whenever the DUT shows mem_en, if_ack or d_ack.
module tb_mem_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 32'h010) return 32'h00A00093;
        return 32'h5A00_0000 ^ (a * 32'h0001_9E37);
    endfunction

    // Memory macro model: fixed-latency read pipeline plus write port.
    logic [DW-1:0] mem [0:511];
    logic [DW-1:0] pipe [0:15];
    bit mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int a = 0; a < 512; a++) mem[a] <= init_val(a);
            mem_init_done <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe[0] <= mem_en ? mem[mem_addr] : 32'h0BAD_0BAD;
        for (int j = 1; j < 16; j++) pipe[j] <= pipe[j-1];
    end
    assign mem_rdata = pipe[L-1];

    // Reference model state (transaction level).
    logic [DW-1:0] ref_mem [0:511];
    logic [DW-1:0] ref_last_d;

    typedef struct { logic [DW-1:0] data; int cyc; } ack_exp_t;
    typedef struct { logic [AW-1:0] addr; bit we; logic [DW-1:0] wdata; int cyc; } mem_exp_t;
    ack_exp_t i_q[$];
    ack_exp_t d_q[$];
    mem_exp_t mem_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an access or ack.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("stall", stall, (if_req & ~if_ack) | ((d_read | d_write) & ~d_ack));
            if (!mem_en) chk("mem_we_outside_issue", mem_we, 1'b0);
            if (mem_en) begin
                if (mem_q.size() == 0) chk("mem_en_unexpected", mem_en, 1'b0);
                else begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    chk("mem_en_cycle", cyc, m.cyc);
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_we", mem_we, m.we);
                    if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end
            if (if_ack) begin
                if (i_q.size() == 0) chk("if_ack_unexpected", if_ack, 1'b0);
                else begin
                    ack_exp_t e;
                    e = i_q.pop_front();
                    chk("if_ack_cycle", cyc, e.cyc);
                    chk("if_rdata", if_rdata, e.data);
                end
            end
            if (d_ack) begin
                if (d_q.size() == 0) chk("d_ack_unexpected", d_ack, 1'b0);
                else begin
                    ack_exp_t e;
                    e = d_q.pop_front();
                    chk("d_ack_cycle", cyc, e.cyc);
                    chk("d_rdata", d_rdata, e.data);
                end
            end
        end
    end

    // Issue one transaction (fetch and/or data raised in the same cycle),
    // predict its outcome, and hold each request until the cycle after its ack.
    task automatic txn(input bit do_i, input bit do_d, input bit dr, input bit dw,
                       input logic [AW-1:0] ia, input logic [AW-1:0] da,
                       input logic [DW-1:0] wd);
        int c0;
        int t;
        int i_st;
        int d_st;
        logic [DW-1:0] v;
        @(posedge clk); #1;
        c0 = cyc;
        if (do_i) begin if_req = 1'b1; if_addr = ia; end
        if (do_d) begin d_read = dr; d_write = dw; d_addr = da; d_wdata = wd; end
        t = c0;
        if (do_d) begin
            mem_q.push_back('{addr: da, we: dw, wdata: wd, cyc: t + 1});
            if (dw) begin
                v = ref_last_d;
                ref_mem[da] = wd;
            end else begin
                v = ref_mem[da];
                ref_last_d = v;
            end
            d_q.push_back('{data: v, cyc: t + L + 2});
            t = t + L + 3;
        end
        if (do_i) begin
            mem_q.push_back('{addr: ia, we: 1'b0, wdata: 32'h0, cyc: t + 1});
            i_q.push_back('{data: ref_mem[ia], cyc: t + L + 2});
        end
        i_st = do_i ? 1 : 0;
        d_st = do_d ? 1 : 0;
        for (int k = 0; k < 64 && (i_st != 0 || d_st != 0); k++) begin
            @(negedge clk);
            if (i_st == 1 && if_ack) i_st = 2;
            if (d_st == 1 && d_ack) d_st = 2;
            @(posedge clk); #1;
            if (i_st == 3) begin if_req = 1'b0; i_st = 0; end
            else if (i_st == 2) i_st = 3;
            if (d_st == 3) begin d_read = 1'b0; d_write = 1'b0; d_st = 0; end
            else if (d_st == 2) d_st = 3;
        end
        if (i_st != 0 || d_st != 0) begin
            chk("ack_timeout", i_st + d_st, 0);
            if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
        end
    endtask

    initial begin
        for (int a = 0; a < 512; a++) ref_mem[a] = init_val(a);
        ref_last_d = 32'h0;
        reset = 1'b1;
        if_req = 1'b0; if_addr = 9'h0;
        d_read = 1'b0; d_write = 1'b0; d_addr = 9'h0; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 if_req = 1'b1;
        @(negedge clk);
        chk("rst_if_ack", if_ack, 1'b0);
        chk("rst_d_ack", d_ack, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 9'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_stall_tracks_req", stall, 1'b1);
        @(posedge clk); #1;
        if_req = 1'b0;
        reset = 1'b0;
        mon_en = 1'b1;

        // Single fetch, store then load, collision, read+write combined.
        txn(1'b1, 1'b0, 1'b0, 1'b0, 9'h010, 9'h000, 32'h0);
        txn(1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 9'h040, 32'hDEADBEEF);
        txn(1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 9'h040, 32'h0);
        txn(1'b1, 1'b1, 1'b1, 1'b0, 9'h020, 9'h044, 32'h0);
        txn(1'b0, 1'b1, 1'b1, 1'b1, 9'h000, 9'h008, 32'h1234_5678);
        txn(1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 9'h008, 32'h0);

        // Reset during WAIT of a read: aborted, no ack, outputs cleared.
        @(posedge clk); #1;
        d_read = 1'b1; d_addr = 9'h00C;
        mem_q.push_back('{addr: 9'h00C, we: 1'b0, wdata: 32'h0, cyc: cyc + 1});
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        d_read = 1'b0;
        @(posedge clk); #1;
        chk("abort_d_ack", d_ack, 1'b0);
        chk("abort_mem_en", mem_en, 1'b0);
        chk("abort_mem_addr", mem_addr, 9'h0);
        chk("abort_d_rdata", d_rdata, 32'h0);
        chk("abort_if_rdata", if_rdata, 32'h0);
        chk("abort_stall", stall, 1'b0);
        reset = 1'b0;
        ref_last_d = 32'h0;
        repeat (10) @(posedge clk);

        // Randomised transactions against the reference model.
        for (int n = 0; n < 60; n++) begin
            bit di;
            bit dd;
            int kind;
            di = 1'($urandom_range(0, 1));
            dd = 1'($urandom_range(0, 1));
            if (!di && !dd) dd = 1'b1;
            kind = $urandom_range(0, 4);
            txn(di, dd, kind != 1, kind == 1 || kind == 4,
                9'($urandom_range(0, 511)), 9'($urandom_range(0, 63)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        chk("pending_expectations", i_q.size() + d_q.size() + mem_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
